// File: rtl/lane_accum_stage_if.sv
// Bus bundle between the HPS memory I/O conduit and the lane accumulator stage.
//   control_data/control_set : control word and its one-cycle strobe (HPS -> stage)
//   input_data/input_set     : 128-bit input word and strobe, no backpressure (HPS -> stage)
//   output_data/output_set   : result word and valid, held until accepted (stage -> HPS)
//   output_waitrequest       : sink stall for the result path (HPS -> stage)
interface lane_accum_stage_if;
  logic [31:0]  control_data;
  logic         control_set;
  logic [127:0] input_data;
  logic         input_set;
  logic [127:0] output_data;
  logic         output_set;
  logic         output_waitrequest;

  modport master (
    output control_data, control_set, input_data, input_set, output_waitrequest,
    input  output_data, output_set
  );

  modport slave (
    input  control_data, control_set, input_data, input_set, output_waitrequest,
    output output_data, output_set
  );
endinterface

// File: rtl/lane_accum_stage.sv
// Lane accumulator stage: buffers input words in a FIFO and, once started, sums each signed
// 32-bit lane over a block of N words, returning one result word through a waitrequest path.
//   clk_clk       : system clock, rising edge
//   reset_reset_n : asynchronous active-low reset
//   bus           : control, input and result signals (slave side)
//   busy          : high while accumulating or emitting
//   overflow      : sticky, an input word was dropped on a full FIFO
//   blocks_done   : number of accepted results, wraps at 2^16
module lane_accum_stage #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned LANE_W     = 32
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  lane_accum_stage_if.slave   bus,
  output logic                busy,
  output logic                overflow,
  output logic [15:0]         blocks_done
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;

  typedef logic [LANES-1:0][LANE_W-1:0] word_t;
  typedef logic [AW-1:0]                ptr_t;
  typedef logic [CntW-1:0]              cnt_t;
  typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

  // Control decode
  logic        start_req, clear_req, abort_req;
  logic [15:0] ctrl_n;
  logic        unused_ctrl_bits;

  assign ctrl_n           = bus.control_data[31:16];
  assign abort_req        = bus.control_set & bus.control_data[2];
  assign clear_req        = bus.control_set & bus.control_data[1];
  // Abort dominates start; N=0 starts are ignored.
  assign start_req        = bus.control_set & bus.control_data[0] & ~bus.control_data[2] &
                            (ctrl_n != 16'd0);
  assign unused_ctrl_bits = ^bus.control_data[15:3];

  // State
  state_e      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  word_t       acc_q, acc_d;
  word_t       out_data_q, out_data_d;
  logic        out_set_q, out_set_d;
  logic [15:0] blocks_q, blocks_d;
  logic        busy_q;
  logic        overflow_q, overflow_d;

  // FIFO
  word_t fifo_mem_q [FIFO_DEPTH];
  ptr_t  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  logic  fifo_empty, fifo_full, push, pop, drop;
  word_t in_word, rd_word;

  assign in_word    = bus.input_data;
  assign rd_word    = fifo_mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == cnt_t'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot on a full FIFO, so the push still lands.
  assign push       = bus.input_set & (~fifo_full | pop);
  assign drop       = bus.input_set & fifo_full & ~pop;

  // Block FSM and datapath
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_set_d   = out_set_q;
    blocks_d    = blocks_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d     = StAccum;
          remaining_d = ctrl_n;
          acc_d       = '0;
        end
      end
      StAccum: begin
        if (abort_req) begin
          state_d = StIdle;
          acc_d   = '0;
        end else if (remaining_q == 16'd0) begin
          // Last pop landed on the previous edge; present the sums now.
          state_d    = StEmit;
          out_data_d = acc_q;
          out_set_d  = 1'b1;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i] + rd_word[i];
          end
          remaining_d = remaining_q - 16'd1;
        end
      end
      StEmit: begin
        if (abort_req) begin
          state_d   = StIdle;
          out_set_d = 1'b0;
          acc_d     = '0;
        end else if (!bus.output_waitrequest) begin
          state_d   = StIdle;
          out_set_d = 1'b0;
          blocks_d  = blocks_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointers and sticky overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort_req) begin
      // Flush, including any word arriving this cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (clear_req) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_set_q   <= 1'b0;
      blocks_q    <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_set_q   <= out_set_d;
      blocks_q    <= blocks_d;
      busy_q      <= (state_d != StIdle);
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= in_word;
  end

  assign bus.output_data = out_data_q;
  assign bus.output_set  = out_set_q;
  assign busy            = busy_q;
  assign overflow        = overflow_q;
  assign blocks_done     = blocks_q;

endmodule
